// File: rtl/fifo_client_pkg.sv
// Shared types and constants for the fifo_client requester endpoint.
package fifo_client_pkg;

  localparam int FC_DW = 32;

  typedef enum logic [1:0] {
    FC_RUN   = 2'd0,
    FC_FLUSH = 2'd1,
    FC_DONE  = 2'd2
  } fc_state_e;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } fc_grant_e;

endpackage

// File: rtl/fc_skid_buf.sv
// DEPTH x DW register FIFO holding read returns until the downstream consumer pops them.
module fc_skid_buf
  import fifo_client_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = FC_DW,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] occ
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // NOTE: storage is not reset; occ gates every read of it, so only control state needs rst.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && occ == CW'(DEPTH)));

endmodule

// File: rtl/fifo_client.sv
// Requester endpoint for the single-port FIFO: arbitrates WE/RE, backs off on rejects,
// and credits read returns into a skid buffer feeding a valid/ready stream.
module fifo_client
  import fifo_client_pkg::*;
#(
  parameter int SKID_DEPTH = 4,
  parameter int BACKOFF    = 4,
  parameter int DW         = FC_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
  input  logic          flush,
  output logic          flush_done,
  output logic [DW-1:0] fifo_di,
  output logic          fifo_we,
  output logic          fifo_re,
  input  logic [DW-1:0] fifo_res,
  input  logic          fifo_read_valid,
  input  logic          fifo_r_err,
  input  logic          fifo_w_err,
  output logic          err_unexp
);

  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam int BW = $clog2(BACKOFF + 1);
  localparam logic [CW:0]   CREDITS = (CW + 1)'(SKID_DEPTH);
  localparam logic [BW-1:0] BO_LOAD = BW'(BACKOFF);

  fc_state_e     state, state_nxt;
  fc_grant_e     last_grant;
  logic [CW-1:0] out_cnt, occ;
  logic [BW-1:0] wr_bo, rd_bo;
  logic          wr_cand, rd_cand, wr_gnt, rd_gnt;
  logic          rd_ok, ret_ok, pop, idle;

  // Requests are masked during rst so the command outputs read 0 as soon as rst rises.
  always_comb begin
    wr_cand = !rst && s_valid && wr_bo == '0 && state == FC_RUN;
    rd_cand = !rst && ({1'b0, out_cnt} + {1'b0, occ}) < CREDITS
              && rd_bo == '0 && state == FC_RUN;
    wr_gnt  = wr_cand && (!rd_cand || last_grant == GRANT_READ);
    rd_gnt  = rd_cand && !wr_gnt;
  end

  assign fifo_we    = wr_gnt;
  assign fifo_re    = rd_gnt;
  assign fifo_di    = wr_gnt ? s_data : '0;
  assign s_ready    = wr_gnt & ~fifo_w_err;
  assign rd_ok      = rd_gnt & ~fifo_r_err;
  assign ret_ok     = fifo_read_valid && out_cnt != '0;
  assign m_valid    = occ != '0;
  assign pop        = m_valid & m_ready;
  assign idle       = out_cnt == '0 && occ == '0;
  assign flush_done = state == FC_DONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FC_RUN;
      last_grant <= GRANT_READ;
      out_cnt    <= '0;
      wr_bo      <= '0;
      rd_bo      <= '0;
      err_unexp  <= 1'b0;
    end else begin
      state   <= state_nxt;
      out_cnt <= out_cnt + CW'(rd_ok) - CW'(ret_ok);
      if (wr_gnt)      last_grant <= GRANT_WRITE;
      else if (rd_gnt) last_grant <= GRANT_READ;
      if (wr_gnt && fifo_w_err) wr_bo <= BO_LOAD;
      else if (wr_bo != '0)     wr_bo <= wr_bo - BW'(1);
      if (rd_gnt && fifo_r_err) rd_bo <= BO_LOAD;
      else if (rd_bo != '0)     rd_bo <= rd_bo - BW'(1);
      if (fifo_read_valid && out_cnt == '0) err_unexp <= 1'b1;
    end
  end

  // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      FC_RUN:   if (flush) state_nxt = FC_FLUSH;
      FC_FLUSH: if (idle)  state_nxt = flush ? FC_DONE : FC_RUN;
      FC_DONE:  if (!flush) state_nxt = FC_RUN;
      default:  state_nxt = FC_RUN;
    endcase
  end

  fc_skid_buf #(.DEPTH(SKID_DEPTH), .DW(DW), .CW(CW)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (ret_ok),
    .din  (fifo_res),
    .pop  (pop),
    .dout (m_data),
    .occ  (occ)
  );

  a_single_port: assert property (@(posedge clk) disable iff (rst) !(fifo_re && fifo_we));

endmodule

// File: tb/tb_fifo_client.sv
// Self-checking bench for fifo_client: a behavioural single-port FIFO answers RE/WE,
// a vector table checks arbitration cycle by cycle, and directed sequences cover corners.
module tb_fifo_client;

  localparam int DW = 32;
  localparam int ENV_DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic          flush = 1'b0;
  logic          flush_done;
  logic [DW-1:0] fifo_di;
  logic          fifo_we, fifo_re;
  logic [DW-1:0] fifo_res;
  logic          fifo_read_valid, fifo_r_err, fifo_w_err;
  logic          err_unexp;

  // Environment controls driven by the stimulus process
  logic          force_w_err = 1'b0;
  logic          ret_hold = 1'b0;
  logic          inj_rv = 1'b0;
  logic          pre_valid = 1'b0;
  logic [DW-1:0] pre_data = '0;

  // Environment state
  logic [DW-1:0] env_q[$];
  logic [DW-1:0] ret_q[$];
  logic [DW-1:0] popped[$];
  int            env_cnt = 0;
  logic          env_rv = 1'b0;
  logic [DW-1:0] env_rd = '0;
  int            acc_re = 0;
  int            both_cnt = 0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_client dut (
    .clk             (clk),
    .rst             (rst),
    .s_valid         (s_valid),
    .s_data          (s_data),
    .s_ready         (s_ready),
    .m_valid         (m_valid),
    .m_data          (m_data),
    .m_ready         (m_ready),
    .flush           (flush),
    .flush_done      (flush_done),
    .fifo_di         (fifo_di),
    .fifo_we         (fifo_we),
    .fifo_re         (fifo_re),
    .fifo_res        (fifo_res),
    .fifo_read_valid (fifo_read_valid),
    .fifo_r_err      (fifo_r_err),
    .fifo_w_err      (fifo_w_err),
    .err_unexp       (err_unexp)
  );

  assign fifo_r_err      = fifo_re & (env_cnt == 0);
  assign fifo_w_err      = fifo_we & (force_w_err | (env_cnt >= ENV_DEPTH));
  assign fifo_read_valid = env_rv | inj_rv;
  assign fifo_res        = inj_rv ? 32'h55 : env_rd;

  // Behavioural FIFO: accepted reads return two cycles later unless held.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      env_q.delete();
      ret_q.delete();
      env_rv  <= 1'b0;
      env_rd  <= '0;
      env_cnt <= 0;
    end else begin
      env_rv <= 1'b0;
      if (!ret_hold && ret_q.size() != 0) begin
        env_rv <= 1'b1;
        env_rd <= ret_q.pop_front();
      end
      if (fifo_re && fifo_we) both_cnt++;
      if (fifo_re && !fifo_r_err) begin
        ret_q.push_back(env_q.pop_front());
        acc_re++;
      end
      if (pre_valid) env_q.push_back(pre_data);
      if (fifo_we && !fifo_w_err) env_q.push_back(fifo_di);
      if (m_valid && m_ready) popped.push_back(m_data);
      env_cnt <= env_q.size();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic preload(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      pre_valid = 1'b1;
      pre_data  = base + DW'(i);
      cyc();
    end
    pre_valid = 1'b0;
  endtask

  typedef struct {
    logic          sv;
    logic [DW-1:0] sd;
    logic          mr;
    logic [3:0]    exp_ctl;  // {we, re, s_ready, m_valid}
    logic [DW-1:0] exp_md;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, pbase, ops;
    bit found;

    // Streaming from the first cycle after reset; write wins the first tie, then they alternate.
    tbl[0] = '{1'b1, 32'h11, 1'b1, 4'b1010, 32'h0};
    tbl[1] = '{1'b1, 32'h22, 1'b1, 4'b0100, 32'h0};
    tbl[2] = '{1'b1, 32'h22, 1'b1, 4'b1010, 32'h0};
    tbl[3] = '{1'b1, 32'h33, 1'b1, 4'b0100, 32'h0};
    tbl[4] = '{1'b1, 32'h33, 1'b1, 4'b1011, 32'h11};
    tbl[5] = '{1'b0, 32'h0,  1'b1, 4'b0100, 32'h0};
    tbl[6] = '{1'b0, 32'h0,  1'b1, 4'b0101, 32'h22};
    tbl[7] = '{1'b0, 32'h0,  1'b1, 4'b0000, 32'h0};
    tbl[8] = '{1'b0, 32'h0,  1'b1, 4'b0001, 32'h33};
    tbl[9] = '{1'b0, 32'h0,  1'b1, 4'b0000, 32'h0};

    // Some traffic, then an asynchronous reset in the middle of a cycle
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'h99;
    m_ready = 1'b1;
    repeat (6) cyc();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("reset_outputs", {26'd0, s_ready, m_valid, fifo_we, fifo_re, flush_done, err_unexp}, 32'h0);
    check("reset_fifo_di", fifo_di, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_valid = tbl[i].sv;
      s_data  = tbl[i].sd;
      m_ready = tbl[i].mr;
      #1;
      check($sformatf("vec%0d_ctl", i), {28'd0, fifo_we, fifo_re, s_ready, m_valid},
            {28'd0, tbl[i].exp_ctl});
      if (tbl[i].exp_ctl[0]) check($sformatf("vec%0d_m_data", i), m_data, tbl[i].exp_md);
      check($sformatf("vec%0d_flush_done", i), {31'd0, flush_done}, 32'h0);
      cyc();
    end

    // Backpressure: credit limits accepted reads to the skid depth
    s_valid = 1'b0;
    m_ready = 1'b0;
    base = acc_re;
    preload(32'h100, 10);
    repeat (30) cyc();
    #1;
    check("bp_accepted_reads", acc_re - base, 32'd4);
    check("bp_m_valid", {31'd0, m_valid}, 32'h1);
    check("bp_head", m_data, 32'h100);
    pbase = popped.size();
    m_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (popped.size() - pbase >= 10) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    check("bp_drain_done", {31'd0, found}, 32'h1);
    for (int i = 0; i < 10; i++)
      if (popped.size() > pbase + i)
        check($sformatf("bp_word%0d", i), popped[pbase + i], 32'h100 + 32'(i));
    check("bp_total_reads", acc_re - base, 32'd10);

    // Flush with two reads outstanding and one word buffered
    m_ready = 1'b0;
    ret_hold = 1'b1;
    base = acc_re;
    preload(32'hA0, 3);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (acc_re - base == 3) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    check("fl_three_reads", {31'd0, found}, 32'h1);
    ret_hold = 1'b0;
    cyc();
    ret_hold = 1'b1;
    cyc();
    #1;
    check("fl_buffered_valid", {31'd0, m_valid}, 32'h1);
    check("fl_buffered_head", m_data, 32'hA0);
    pbase = popped.size();
    ops = 0;
    flush = 1'b1;
    cyc();
    s_valid = 1'b1;
    s_data  = 32'h77;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (fifo_re || fifo_we || s_ready) ops++;
      cyc();
    end
    ret_hold = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (fifo_re || fifo_we || s_ready) ops++;
      cyc();
    end
    #1;
    check("fl_not_done_unpopped", {31'd0, flush_done}, 32'h0);
    m_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      #1;
      if (fifo_re || fifo_we || s_ready) ops++;
      if (flush_done) begin
        found = 1'b1;
        break;
      end
    end
    check("fl_done", {31'd0, found}, 32'h1);
    check("fl_pops", popped.size() - pbase, 32'd3);
    for (int i = 0; i < 3; i++)
      if (popped.size() > pbase + i)
        check($sformatf("fl_word%0d", i), popped[pbase + i], 32'hA0 + 32'(i));
    check("fl_no_commands", ops, 32'd0);
    s_valid = 1'b0;
    flush = 1'b0;
    cyc();
    #1;
    check("fl_release", {31'd0, flush_done}, 32'h0);

    // Write rejected by w_err, suppressed for BACKOFF cycles, then retried
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 32'hDEADBEEF;
    force_w_err = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (fifo_we) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    check("we_issued", {31'd0, found}, 32'h1);
    check("we_rejected_ready", {31'd0, s_ready}, 32'h0);
    cyc();
    force_w_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("we_backoff%0d", i), {31'd0, fifo_we}, 32'h0);
      cyc();
    end
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (fifo_we) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    check("we_retry", {31'd0, found}, 32'h1);
    check("we_retry_ready", {31'd0, s_ready}, 32'h1);
    check("we_retry_data", fifo_di, 32'hDEADBEEF);
    cyc();
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (30) cyc();
    check("we_delivered", popped.size() != 0 ? popped[$] : 32'h0, 32'hDEADBEEF);

    // Spurious return with nothing outstanding
    #1;
    check("sp_err_before", {31'd0, err_unexp}, 32'h0);
    check("sp_mv_before", {31'd0, m_valid}, 32'h0);
    @(negedge clk);
    inj_rv = 1'b1;
    cyc();
    inj_rv = 1'b0;
    #1;
    check("sp_err_set", {31'd0, err_unexp}, 32'h1);
    check("sp_mv_after", {31'd0, m_valid}, 32'h0);
    repeat (5) cyc();
    #1;
    check("sp_err_sticky", {31'd0, err_unexp}, 32'h1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("sp_err_cleared", {31'd0, err_unexp}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    check("re_we_exclusive", both_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_client.md
Name: fifo_client

Overview:
- Requester-side endpoint for the single-port FIFO command interface (DI/WE/RE in; res/read_valid/r_err/w_err out).
- Converts an upstream valid/ready write stream into WE/DI commands, and issues RE commands autonomously.
- Collects read_valid/res returns into a credit-managed skid buffer feeding a downstream valid/ready stream.
- Arbitrates writes vs reads so RE and WE are never high together (single-port storage); supports flush and error backoff.

Parameters:
- SKID_DEPTH, 4: return-buffer entries; also the max reads in flight plus buffered.
- BACKOFF, 4: cycles a request class is suppressed after an r_err/w_err rejection.
- DW, 32: data width; fixed to the FIFO data width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  upstream write word valid
- s_data  in  DW  upstream write word
- s_ready  out  1  word accepted by FIFO this cycle
- m_valid  out  1  downstream read word valid
- m_data  out  DW  downstream read word
- m_ready  in  1  downstream accepts
- flush  in  1  level; stop issuing, drain in-flight returns
- flush_done  out  1  flush complete, nothing in flight or buffered
- fifo_di  out  DW  to FIFO DI
- fifo_we  out  1  to FIFO WE
- fifo_re  out  1  to FIFO RE
- fifo_res  in  DW  FIFO read data
- fifo_read_valid  in  1  FIFO read data valid
- fifo_r_err  in  1  same-cycle read reject (empty)
- fifo_w_err  in  1  same-cycle write reject (full)
- err_unexp  out  1  sticky; read_valid arrived with no read outstanding

Behaviour:
- Reset: async on rst high.
  - Values: s_ready=0, m_valid=0, fifo_we=0, fifo_re=0, flush_done=0, err_unexp=0, fifo_di=0.
  - Counters zero; state RUN; last_grant=READ, so write wins first tie.
  - FIFO shares rst, so no returns survive reset.
- Error timing: fifo_r_err/fifo_w_err are same-cycle responses to RE/WE.
  - A rejected request has no effect and produces no read_valid.
- Write candidate: s_valid & wr_bo==0 & state==RUN.
- Read candidate: (out_cnt+occ)<SKID_DEPTH & rd_bo==0 & state==RUN.
- Arbitration:
  - One candidate: it is granted.
  - Both: grant opposite of last_grant.
  - last_grant updates only on a grant.
- Write grant:
  - fifo_we=1, fifo_di=s_data.
  - s_ready=fifo_we & ~fifo_w_err (combinational).
  - On w_err: wr_bo<=BACKOFF; the same word is retried later, since s_valid/s_data must hold until s_ready.
- Read grant:
  - fifo_re=1.
  - If ~fifo_r_err, out_cnt increments.
  - On r_err, rd_bo<=BACKOFF.
- Backoff counters decrement each cycle toward 0, independently.
- Return path:
  - fifo_read_valid & out_cnt>0: push fifo_res into the skid buffer and decrement out_cnt.
  - Return and new accepted read in the same cycle: out_cnt unchanged.
  - fifo_read_valid & out_cnt==0: err_unexp<=1 (sticky until rst), data dropped.
- Skid buffer:
  - m_valid=occ!=0, m_data=head; pop on m_valid&m_ready.
  - Push and pop in the same cycle are allowed; occ unchanged.
  - Overflow is impossible by credit; an assertion checks it.
- Latency: read_valid to m_valid is 1 cycle (registered push); an empty buffer does not bypass.
- FSM:
  - RUN -> FLUSH when flush=1.
  - FLUSH: no new RE/WE, s_ready=0, returns still accepted, downstream pops continue.
  - FLUSH -> DONE when out_cnt==0 & occ==0.
  - DONE: flush_done=1.
  - DONE -> RUN when flush=0.
  - FLUSH -> RUN if flush drops early, only once out_cnt==0 & occ==0; otherwise complete via DONE.
- Widths: out_cnt, occ are $clog2(SKID_DEPTH+1) bits; comparisons are zero-extended.
- Invariant: fifo_re & fifo_we never both 1.

Decomposition:
- Shared include param_define.v gets:
  - FC_DW=32.
  - State encodings FC_RUN=2'd0, FC_FLUSH=2'd1, FC_DONE=2'd2.
- One sub-module, fc_skid_buf: a DEPTH x DW register FIFO.
  - Ports: push, din, pop, dout, occ.
  - Circular pointers with wrap at DEPTH.

Test Plan:
- Reset: rst pulse mid-traffic -> all outputs 0 in the same cycle as the rst edge; out_cnt=0; first tie after release grants write.
- Streaming: write 0x11, 0x22, 0x33 with m_ready=1 -> m_data emits 0x11, 0x22, 0x33 in order; RE/WE never coincide and alternate on ties.
- Backpressure: FIFO preloaded with 10 words, m_ready=0 -> exactly 4 accepted REs, then fifo_re stays 0; m_ready=1 -> reads resume, all 10 words delivered in order.
- w_err: force fifo_w_err on a write of 0xDEADBEEF -> s_ready=0 that cycle, fifo_we=0 for next 4 cycles, retry accepted with same data.
- Flush: assert flush with 2 reads outstanding and 1 buffered -> no further RE/WE, flush_done=1 only after 2 read_valids returned and 3 pops; release flush -> RUN.
- Spurious return: inject fifo_read_valid with out_cnt=0 -> err_unexp=1 and stays 1, m_valid unchanged; cleared only by rst.
